// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data-memory port between the CPU MEM stage and a debug/DMA port.
// Latency: writes ack in the issue cycle, reads ack one cycle after issue (synchronous memory).
// Backpressure: a losing or read-pending port gets no ack (CPU sees c_stall); debug is forced through after STARVE_MAX denials.
module dmem_arbiter #(
  parameter int DW         = 32,
  parameter int AW         = 32,
  parameter int STARVE_MAX = 8
) (
  input  logic          clk,
  input  logic          rst,
  // CPU MEM-stage port
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wd,
  output logic [DW-1:0] c_rd,
  output logic          c_ack,
  output logic          c_stall,
  // debug / DMA port
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wd,
  output logic [DW-1:0] d_rd,
  output logic          d_ack,
  // data memory port
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wd,
  input  logic [DW-1:0] m_rd
);

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  // a set pend flag means that port's read data arrives on m_rd this cycle
  logic          c_pend;
  logic          d_pend;
  logic [7:0]    starve_cnt;
  logic [DW-1:0] c_rd_q;
  logic [DW-1:0] d_rd_q;

  logic          c_elig;
  logic          d_elig;
  logic          gnt_c;
  logic          gnt_d;

  // Grant selection: starved debug first, then CPU, then debug
  always_comb begin
    c_elig = c_req & ~c_pend;
    d_elig = d_req & ~d_pend;
    gnt_d  = d_elig & ((starve_cnt == STARVE_LIM) | ~c_elig);
    gnt_c  = c_elig & ~gnt_d;
  end

  // Memory-side mux; idle cycles drive a quiet all-zero command
  always_comb begin
    m_en   = gnt_c | gnt_d;
    m_we   = 1'b0;
    m_addr = '0;
    m_wd   = '0;
    if (gnt_d) begin
      m_we   = d_we;
      m_addr = d_addr;
      m_wd   = d_wd;
    end else if (gnt_c) begin
      m_we   = c_we;
      m_addr = c_addr;
      m_wd   = c_wd;
    end
  end

  // Requester responses: writes ack on grant, reads ack in the response slot
  always_comb begin
    c_ack   = c_pend | (gnt_c & c_we);
    d_ack   = d_pend | (gnt_d & d_we);
    c_rd    = c_pend ? m_rd : c_rd_q;
    d_rd    = d_pend ? m_rd : d_rd_q;
    c_stall = c_req & ~c_ack;
  end

  // Outstanding-read tracking and read-data hold registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_pend <= 1'b0;
      d_pend <= 1'b0;
      c_rd_q <= '0;
      d_rd_q <= '0;
    end else begin
      // a granted port is never pending, so the flag lives exactly one cycle
      c_pend <= gnt_c & ~c_we;
      d_pend <= gnt_d & ~d_we;
      if (c_pend) c_rd_q <= m_rd;
      if (d_pend) d_rd_q <= m_rd;
    end
  end

  // Debug starvation counter: counts eligible-but-denied cycles, saturating
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (!d_req || gnt_d) begin
      starve_cnt <= '0;
    end else if (d_elig && (starve_cnt != STARVE_LIM)) begin
      starve_cnt <= starve_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed table, corner-case sequences and random traffic against a reference model.
// Latency: the reference model predicts same-cycle write acks and next-cycle read acks.
// Backpressure: requesters hold each access until the predicted ack, then may start another.
module tb_dmem_arbiter;

  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int SMAX = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          c_req = 1'b0, c_we = 1'b0;
  logic [AW-1:0] c_addr = '0;
  logic [DW-1:0] c_wd = '0;
  logic [DW-1:0] c_rd;
  logic          c_ack, c_stall;
  logic          d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wd = '0;
  logic [DW-1:0] d_rd;
  logic          d_ack;
  logic          m_en, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wd;
  logic [DW-1:0] m_rd = '0;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DW(DW), .AW(AW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wd(c_wd), .c_rd(c_rd), .c_ack(c_ack), .c_stall(c_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wd(d_wd), .d_rd(d_rd), .d_ack(d_ack),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wd(m_wd), .m_rd(m_rd)
  );

  // Behavioural synchronous data memory driven by the DUT's memory port
  logic [DW-1:0] mem [0:255];
  always @(posedge clk) begin
    if (m_en) begin
      if (m_we) mem[m_addr[9:2]] <= m_wd;
      else      m_rd <= mem[m_addr[9:2]];
    end
  end

  // ---------------- reference model ----------------
  logic [DW-1:0] img [0:255];       // expected memory contents in issue order
  bit            ref_c_due, ref_d_due;  // a read response is owed this cycle
  logic [DW-1:0] ref_c_dat, ref_d_dat;
  int            ref_wait;          // consecutive eligible-but-denied debug cycles
  int            win;               // 0 none, 1 cpu, 2 debug
  bit            e_c_ack, e_d_ack, e_c_stall, e_m_en, e_m_we;
  logic [AW-1:0] e_m_addr;
  logic [DW-1:0] e_m_wd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    ref_c_due = 1'b0;
    ref_d_due = 1'b0;
    ref_wait  = 0;
  endtask

  task automatic model_eval();
    bit cr, dr;
    cr = c_req && !ref_c_due;
    dr = d_req && !ref_d_due;
    if (dr && (ref_wait >= SMAX || !cr)) win = 2;
    else if (cr)                          win = 1;
    else                                  win = 0;
    e_c_ack   = ref_c_due || (win == 1 && c_we);
    e_d_ack   = ref_d_due || (win == 2 && d_we);
    e_c_stall = c_req && !e_c_ack;
    e_m_en    = (win != 0);
    e_m_we    = (win == 1) ? c_we : (win == 2) ? d_we : 1'b0;
    e_m_addr  = (win == 2) ? d_addr : c_addr;
    e_m_wd    = (win == 2) ? d_wd : c_wd;
  endtask

  task automatic model_check();
    model_eval();
    chk("m_en", 32'(m_en), 32'(e_m_en));
    chk("m_we", 32'(m_we), 32'(e_m_we));
    if (e_m_en) chk("m_addr", m_addr, e_m_addr);
    if (e_m_en && e_m_we) chk("m_wd", m_wd, e_m_wd);
    chk("c_ack", 32'(c_ack), 32'(e_c_ack));
    chk("d_ack", 32'(d_ack), 32'(e_d_ack));
    chk("c_stall", 32'(c_stall), 32'(e_c_stall));
    if (ref_c_due) chk("c_rd", c_rd, ref_c_dat);
    if (ref_d_due) chk("d_rd", d_rd, ref_d_dat);
    chk("starve_cnt", 32'(dut.starve_cnt), 32'(ref_wait));
    chk("c_pend", 32'(dut.c_pend), 32'(ref_c_due));
  endtask

  task automatic model_update();
    bit nc, nd;
    model_eval();
    nc = (win == 1) && !c_we;
    nd = (win == 2) && !d_we;
    if (win == 1) begin
      if (c_we) img[c_addr[9:2]] = c_wd;
      else      ref_c_dat = img[c_addr[9:2]];
    end
    if (win == 2) begin
      if (d_we) img[d_addr[9:2]] = d_wd;
      else      ref_d_dat = img[d_addr[9:2]];
    end
    if (!d_req || win == 2)                          ref_wait = 0;
    else if (!ref_d_due && ref_wait < SMAX)          ref_wait = ref_wait + 1;
    ref_c_due = nc;
    ref_d_due = nd;
  endtask

  task automatic to_neg(input bit mchk);
    @(negedge clk);
    if (mchk) model_check();
  endtask

  task automatic to_next();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wd = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wd = '0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic c_req, c_we; logic [31:0] c_addr, c_wd;
    logic d_req, d_we; logic [31:0] d_addr, d_wd;
    logic m_en, m_we; logic [31:0] m_addr;
    logic c_ack, d_ack, c_stall;
    logic chk_crd, chk_drd; logic [31:0] rd;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cack_n, dack_n;
    bit c_busy, d_busy, got;

    for (int i = 0; i < 256; i++) begin
      mem[i] = '0;
      img[i] = '0;
    end
    model_reset();

    //           c_req c_we  c_addr    c_wd           d_req d_we  d_addr    d_wd           m_en  m_we  m_addr    c_ack d_ack stall crd   drd   rd
    tbl[0]  = '{1'b1,1'b1,32'h10,32'hDEADBEEF, 1'b0,1'b0,32'h00,32'h0,        1'b1,1'b1,32'h10, 1'b1,1'b0,1'b0, 1'b0,1'b0,32'h0};
    tbl[1]  = '{1'b1,1'b0,32'h10,32'h0,        1'b0,1'b0,32'h00,32'h0,        1'b1,1'b0,32'h10, 1'b0,1'b0,1'b1, 1'b0,1'b0,32'h0};
    tbl[2]  = '{1'b1,1'b0,32'h10,32'h0,        1'b0,1'b0,32'h00,32'h0,        1'b0,1'b0,32'h00, 1'b1,1'b0,1'b0, 1'b1,1'b0,32'hDEADBEEF};
    tbl[3]  = '{1'b0,1'b0,32'h00,32'h0,        1'b1,1'b1,32'h20,32'h12345678, 1'b1,1'b1,32'h20, 1'b0,1'b1,1'b0, 1'b0,1'b0,32'h0};
    tbl[4]  = '{1'b1,1'b0,32'h10,32'h0,        1'b1,1'b0,32'h20,32'h0,        1'b1,1'b0,32'h10, 1'b0,1'b0,1'b1, 1'b0,1'b0,32'h0};
    tbl[5]  = '{1'b1,1'b0,32'h10,32'h0,        1'b1,1'b0,32'h20,32'h0,        1'b1,1'b0,32'h20, 1'b1,1'b0,1'b0, 1'b1,1'b0,32'hDEADBEEF};
    tbl[6]  = '{1'b0,1'b0,32'h00,32'h0,        1'b1,1'b0,32'h20,32'h0,        1'b0,1'b0,32'h00, 1'b0,1'b1,1'b0, 1'b0,1'b1,32'h12345678};
    tbl[7]  = '{1'b0,1'b0,32'h00,32'h0,        1'b0,1'b0,32'h00,32'h0,        1'b0,1'b0,32'h00, 1'b0,1'b0,1'b0, 1'b0,1'b0,32'h0};
    tbl[8]  = '{1'b1,1'b1,32'h30,32'hAAAA5555, 1'b1,1'b1,32'h34,32'h5555AAAA, 1'b1,1'b1,32'h30, 1'b1,1'b0,1'b0, 1'b0,1'b0,32'h0};
    tbl[9]  = '{1'b0,1'b0,32'h00,32'h0,        1'b1,1'b1,32'h34,32'h5555AAAA, 1'b1,1'b1,32'h34, 1'b0,1'b1,1'b0, 1'b0,1'b0,32'h0};
    tbl[10] = '{1'b1,1'b0,32'h34,32'h0,        1'b0,1'b0,32'h00,32'h0,        1'b1,1'b0,32'h34, 1'b0,1'b0,1'b1, 1'b0,1'b0,32'h0};
    tbl[11] = '{1'b1,1'b0,32'h34,32'h0,        1'b0,1'b0,32'h00,32'h0,        1'b0,1'b0,32'h00, 1'b1,1'b0,1'b0, 1'b1,1'b0,32'h5555AAAA};

    // reset: asserted asynchronously, state checked while held, released after an edge
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_c_ack", 32'(c_ack), 32'd0);
    chk("rst_d_ack", 32'(d_ack), 32'd0);
    chk("rst_c_rd", c_rd, 32'd0);
    chk("rst_d_rd", d_rd, 32'd0);
    chk("rst_m_en", 32'(m_en), 32'd0);
    chk("rst_c_stall", 32'(c_stall), 32'd0);
    chk("rst_starve", 32'(dut.starve_cnt), 32'd0);
    @(posedge clk); #1 rst = 1'b1;

    // directed table
    for (int i = 0; i < 12; i++) begin
      c_req = tbl[i].c_req; c_we = tbl[i].c_we; c_addr = tbl[i].c_addr; c_wd = tbl[i].c_wd;
      d_req = tbl[i].d_req; d_we = tbl[i].d_we; d_addr = tbl[i].d_addr; d_wd = tbl[i].d_wd;
      to_neg(1'b1);
      chk($sformatf("t%0d_m_en", i), 32'(m_en), 32'(tbl[i].m_en));
      chk($sformatf("t%0d_m_we", i), 32'(m_we), 32'(tbl[i].m_we));
      if (tbl[i].m_en) chk($sformatf("t%0d_m_addr", i), m_addr, tbl[i].m_addr);
      chk($sformatf("t%0d_c_ack", i), 32'(c_ack), 32'(tbl[i].c_ack));
      chk($sformatf("t%0d_d_ack", i), 32'(d_ack), 32'(tbl[i].d_ack));
      chk($sformatf("t%0d_c_stall", i), 32'(c_stall), 32'(tbl[i].c_stall));
      if (tbl[i].chk_crd) chk($sformatf("t%0d_c_rd", i), c_rd, tbl[i].rd);
      if (tbl[i].chk_drd) chk($sformatf("t%0d_d_rd", i), d_rd, tbl[i].rd);
      to_next();
    end
    idle_inputs();
    to_neg(1'b1); to_next();

    // starvation: CPU write stream against a held debug read of 0x10
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
    c_req = 1'b1; c_we = 1'b1; c_addr = 32'h40; c_wd = 32'h100;
    for (int k = 0; k < 4; k++) begin
      to_neg(1'b1);
      chk($sformatf("starve_cnt_%0d", k), 32'(dut.starve_cnt), 32'(k));
      if (k < 3) begin
        chk($sformatf("starve_cpu_win_%0d", k), m_addr, c_addr);
        chk($sformatf("starve_cpu_ack_%0d", k), 32'(c_ack), 32'd1);
      end else begin
        chk("starve_dbg_win", m_addr, 32'h10);
        chk("starve_cpu_stall", 32'(c_stall), 32'd1);
        chk("starve_cpu_noack", 32'(c_ack), 32'd0);
      end
      to_next();
      if (k < 3) begin
        c_addr = c_addr + 32'd4;
        c_wd   = c_wd + 32'd1;
      end
    end
    to_neg(1'b1);
    chk("starve_cnt_after", 32'(dut.starve_cnt), 32'd0);
    chk("starve_d_ack", 32'(d_ack), 32'd1);
    chk("starve_d_rd", d_rd, 32'hDEADBEEF);
    chk("starve_cpu_resume", 32'(c_ack), 32'd1);
    to_next();
    idle_inputs();

    // debug preload of 0..15, then CPU readback of all 16 words
    cack_n = 0; dack_n = 0;
    for (int i = 0; i < 16; i++) begin
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'(i * 4); d_wd = 32'(i);
      to_neg(1'b1);
      if (d_ack) dack_n++;
      if (c_ack) cack_n++;
      to_next();
    end
    idle_inputs();
    for (int i = 0; i < 16; i++) begin
      c_req = 1'b1; c_we = 1'b0; c_addr = 32'(i * 4);
      got = 1'b0;
      for (int t = 0; t < 4 && !got; t++) begin
        to_neg(1'b1);
        if (d_ack) dack_n++;
        if (c_ack) begin
          cack_n++;
          got = 1'b1;
          chk($sformatf("readback_%0d", i), c_rd, 32'(i));
        end
        to_next();
      end
      if (!got) chk($sformatf("readback_timeout_%0d", i), 32'd0, 32'd1);
      c_req = 1'b0;
    end
    chk("preload_d_acks", 32'(dack_n), 32'd16);
    chk("readback_c_acks", 32'(cack_n), 32'd16);

    // reset while a CPU read is in flight
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h08;
    to_neg(1'b1);
    chk("midrd_issue", 32'(m_en), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("midrd_c_ack", 32'(c_ack), 32'd0);
    chk("midrd_c_pend", 32'(dut.c_pend), 32'd0);
    chk("midrd_starve", 32'(dut.starve_cnt), 32'd0);
    model_reset();
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrd_dropped", 32'(c_ack), 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    to_neg(1'b1);
    chk("midrd_reissue", 32'(m_en), 32'd1);
    chk("midrd_reissue_stall", 32'(c_stall), 32'd1);
    to_next();
    to_neg(1'b1);
    chk("midrd_done_ack", 32'(c_ack), 32'd1);
    chk("midrd_done_rd", c_rd, 32'd2);
    to_next();
    idle_inputs();

    // idle for 10 cycles
    for (int i = 0; i < 10; i++) begin
      to_neg(1'b1);
      chk("idle_m_en", 32'(m_en), 32'd0);
      chk("idle_c_stall", 32'(c_stall), 32'd0);
      chk("idle_acks", 32'({c_ack, d_ack}), 32'd0);
      chk("idle_starve", 32'(dut.starve_cnt), 32'd0);
      to_next();
    end

    // random traffic on both ports over a small address window
    c_busy = 1'b0; d_busy = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (!c_busy && $urandom_range(0, 3) != 0) begin
        c_busy = 1'b1; c_req = 1'b1; c_we = 1'($urandom_range(0, 1));
        c_addr = 32'($urandom_range(0, 15)) << 2; c_wd = $urandom;
      end
      if (!d_busy && $urandom_range(0, 2) != 0) begin
        d_busy = 1'b1; d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
        d_addr = 32'($urandom_range(0, 15)) << 2; d_wd = $urandom;
      end
      to_neg(1'b1);
      to_next();
      if (c_busy && e_c_ack) begin c_busy = 1'b0; c_req = 1'b0; end
      if (d_busy && e_d_ack) begin d_busy = 1'b0; d_req = 1'b0; end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single data-memory port of the pipelined MIPS SoC between the CPU MEM stage and a debug/DMA port, which the bench uses for memory preload and result readback. It sits between the core's data bus and the memory-mapped data memory. It issues at most one access per cycle, tracks outstanding synchronous reads, and drives a stall into the CPU pipeline while the CPU access is incomplete. By default the CPU has priority, and a starvation counter bounds how long the debug port can wait.

## Interface

- `DW`, 32: data width.
- `AW`, 32: byte address width, passed through unchanged.
- `STARVE_MAX`, 8: number of consecutive cycles the debug port may be denied before it is forced to win. Range 1..255.
- `clk`  in  1: the single clock, rising edge.
- `rst`  in  1: reset. Asynchronous and active-low.
- `c_req`  in  1: CPU access request. Held with `c_we`/`c_addr`/`c_wd` stable until `c_ack`.
- `c_we`  in  1: CPU write enable.
- `c_addr`  in  AW: CPU address.
- `c_wd`  in  DW: CPU write data.
- `c_rd`  out  DW: CPU read data. Valid only when `c_ack` is high and the access is a read.
- `c_ack`  out  1: CPU access complete, one-cycle pulse.
- `c_stall`  out  1: pipeline stall, equal to `c_req & ~c_ack` (combinational).
- `d_req`, `d_we`, `d_addr`, `d_wd`, `d_rd`, `d_ack`: debug-port equivalents of the CPU signals, with identical widths and rules.
- `m_en`  out  1: memory access issued this cycle.
- `m_we`  out  1: memory write enable.
- `m_addr`  out  AW: memory address.
- `m_wd`  out  DW: memory write data.
- `m_rd`  in  DW: memory read data, valid the cycle after a read issue.

## Operation

- Eligibility: a port is eligible when its `req` is high and it has no outstanding read (`c_pend`/`d_pend` = 0).
- Grant selection (combinational, every cycle):
  - Debug wins if it is eligible and `starve_cnt == STARVE_MAX`.
  - Otherwise the CPU wins if it is eligible.
  - Otherwise debug wins if it is eligible.
  - Otherwise there is no grant, and `m_en=0`, `m_we=0`.
- Mux: `m_addr`, `m_wd` and `m_we` come from the granted port. `m_en` = 1 when any port is granted.
- Write issue: the granted port's `ack` is asserted in the same cycle and the access retires there.
- Read issue: the granted port's `pend` flag is set at the clock edge. In the next cycle that port's `ack` is 1, its `rd` = `m_rd`, and `pend` clears at the end of that cycle.
- Pipelined issue: a new access by the other port may issue in the same cycle as a read response. A port never issues twice back-to-back for reads.
- Starvation counter `starve_cnt` (8 bits):
  - Increments when `d_req` is high, debug is eligible and debug is not granted.
  - Resets to 0 when debug is granted or `d_req` is low.
  - Saturates at `STARVE_MAX`.
- Write-then-read ordering: memory order equals issue order. A write issued in cycle N is visible to a read issued in cycle N+1.
- `rd` outputs hold the last response value when `ack` is low. Consumers must not rely on this.
- Requesters must not drop `req` before `ack`. If they do, the arbiter's behaviour is undefined except that `pend` still completes.
- Reset (`rst` low, asynchronous): `c_pend`, `d_pend` and `starve_cnt` go to 0. `c_ack`, `d_ack`, `c_rd` and `d_rd` go to 0. Combinational outputs follow from the cleared state. A read in flight when reset is asserted is dropped and no ack is ever produced for it.

## Timing

- Write latency is 0 cycles. With no contention, `ack` rises in the same cycle as `req` and `c_stall` stays low.
- Read latency is 1 cycle. `c_stall` is high in the issue cycle and low in the response cycle.
- Throughput is one memory access per cycle. Two ports doing alternating reads sustain 100% `m_en`.
- Under contention the debug port's worst-case wait is `STARVE_MAX`+1 cycles from its first eligible cycle, plus one extra cycle if the CPU holds the response slot.
- `c_stall` is purely combinational from `c_req`, the grant and `c_pend`. The CPU must register its stall response and must not feed `c_stall` back into `c_req` in the same cycle.
- All state updates on the rising edge of `clk`. Reset is asynchronous on assertion. Reset release is applied at a clock edge in the environment.

## Test plan

- CPU write only: `c_req=1`, `c_we=1`, `c_addr=0x10`, `c_wd=0xDEADBEEF`. Expect `m_en=1`, `m_we=1` and `c_ack=1` in the same cycle, `c_stall=0`. A following read of `0x10` returns `0xDEADBEEF` with `c_ack` one cycle after issue and `c_stall=1` for exactly one cycle.
- Simultaneous reads: `c_req` and `d_req` both read in cycle 0.
  - Cycle 0: CPU issues.
  - Cycle 1: CPU acks and debug issues.
  - Cycle 2: debug acks.
  - `m_en=1` in cycles 0 and 1.
- Starvation, with `STARVE_MAX=3`: the CPU issues a back-to-back write stream while `d_req` read is held. Debug is granted on its 4th eligible cycle, `starve_cnt` returns to 0, and the CPU sees `c_stall=1` in that cycle.
- Debug preload then CPU readback: the debug port writes `0..15` to addresses `0x00..0x3C`, then the CPU reads all 16. Each `c_rd` matches, with no lost or duplicated acks (16 `d_ack` and 16 `c_ack` pulses).
- Reset mid-read: a CPU read is issued and `rst` is pulled low before the next edge. `c_ack` stays 0, `c_pend=0` and `starve_cnt=0`. After release with `c_req` still high, the read reissues and completes normally.
- Idle: both `req` signals low for 10 cycles. `m_en=0`, `c_stall=0`, no acks, and `starve_cnt` stays 0.
